// File: rtl/uart_cmd_responder_if.sv
// Parallel-side UART byte handshake plus single-cycle register bus seen by the command responder.
interface uart_cmd_responder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  rx_en_out;
  logic [DATA_WIDTH-1:0] rxdata_in;
  logic                  done_receive_in;
  logic                  tx_en_out;
  logic [DATA_WIDTH-1:0] txdata_out;
  logic                  done_transmit_in;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic [DATA_WIDTH-1:0] mem_wdata_out;
  logic                  mem_we_out;
  logic                  mem_re_out;
  logic [DATA_WIDTH-1:0] mem_rdata_in;
  logic                  busy_out;
  logic                  overrun_out;

  modport slave (
    output rx_en_out, tx_en_out, txdata_out, mem_addr_out, mem_wdata_out,
           mem_we_out, mem_re_out, busy_out, overrun_out,
    input  rxdata_in, done_receive_in, done_transmit_in, mem_rdata_in
  );

  modport master (
    input  rx_en_out, tx_en_out, txdata_out, mem_addr_out, mem_wdata_out,
           mem_we_out, mem_re_out, busy_out, overrun_out,
    output rxdata_in, done_receive_in, done_transmit_in, mem_rdata_in
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// Decodes 'W' ADDR DATA / 'R' ADDR byte commands from the UART, performs one bus access
// and answers with a single reply byte (ACK, read data or NAK).
module uart_cmd_responder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  uart_cmd_responder_if.slave  bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] CMD_WR    = DATA_WIDTH'(8'h57);
  localparam logic [DATA_WIDTH-1:0] CMD_RD    = DATA_WIDTH'(8'h52);
  localparam logic [DATA_WIDTH-1:0] REPLY_ACK = DATA_WIDTH'(8'h06);
  localparam logic [DATA_WIDTH-1:0] REPLY_NAK = DATA_WIDTH'(8'h15);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, MEM_WAIT, TX_START, TX_WAIT
  } state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [ADDR_WIDTH-1:0] addr, addr_nx;
  logic [DATA_WIDTH-1:0] wdata, wdata_nx;
  logic [DATA_WIDTH-1:0] txdata, txdata_nx;
  logic                  is_wr, is_wr_nx;
  logic                  accepting;
  logic                  overrun;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= IDLE;
      cnt     <= '0;
      addr    <= '0;
      wdata   <= '0;
      txdata  <= '0;
      is_wr   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      addr    <= addr_nx;
      wdata   <= wdata_nx;
      txdata  <= txdata_nx;
      is_wr   <= is_wr_nx;
      // a byte arriving while the bus access or reply is in flight is lost
      overrun <= bus.done_receive_in && !accepting;
    end
  end

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    addr_nx        = addr;
    wdata_nx       = wdata;
    txdata_nx      = txdata;
    is_wr_nx       = is_wr;
    accepting      = 1'b0;
    bus.tx_en_out  = 1'b0;
    bus.mem_we_out = 1'b0;
    bus.mem_re_out = 1'b0;
    case (state)
      IDLE: begin
        accepting = 1'b1;
        if (bus.done_receive_in) begin
          if (bus.rxdata_in == CMD_WR || bus.rxdata_in == CMD_RD) begin
            is_wr_nx = (bus.rxdata_in == CMD_WR);
            cnt_nx   = '0;
            state_nx = GET_ADDR;
          end else begin
            txdata_nx = REPLY_NAK;
            state_nx  = TX_START;
          end
        end
      end
      GET_ADDR: begin
        accepting = 1'b1;
        // an arriving byte beats a simultaneous timeout
        if (bus.done_receive_in) begin
          addr_nx  = ADDR_WIDTH'(bus.rxdata_in);
          cnt_nx   = '0;
          state_nx = is_wr ? GET_DATA : MEM_RD;
        end else if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = sat_inc(cnt);
        end
      end
      GET_DATA: begin
        accepting = 1'b1;
        if (bus.done_receive_in) begin
          wdata_nx = bus.rxdata_in;
          cnt_nx   = '0;
          state_nx = MEM_WR;
        end else if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = sat_inc(cnt);
        end
      end
      MEM_WR: begin
        bus.mem_we_out = 1'b1;
        txdata_nx      = REPLY_ACK;
        state_nx       = TX_START;
      end
      MEM_RD: begin
        bus.mem_re_out = 1'b1;
        state_nx       = MEM_WAIT;
      end
      MEM_WAIT: begin
        txdata_nx = bus.mem_rdata_in;
        state_nx  = TX_START;
      end
      TX_START: begin
        bus.tx_en_out = 1'b1;
        state_nx      = TX_WAIT;
      end
      TX_WAIT: begin
        if (bus.done_transmit_in) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.rx_en_out     = ~rst_in;
  assign bus.txdata_out    = txdata;
  assign bus.mem_addr_out  = addr;
  assign bus.mem_wdata_out = wdata;
  assign bus.busy_out      = (state != IDLE);
  assign bus.overrun_out   = overrun;
endmodule
